// File: rtl/led_sequence_checker.sv
`default_nettype none
// ============================================================================
// Module   : led_sequence_checker
// Purpose  : Passive checker for a one-hot running-light LED bus. Tracks the
//            rotate-left / rotate-right sequence selected by mode. Reports
//            lock, invalid steps, stalls and valid-step counts.
// Revision : 1.0 - initial release
// ============================================================================
module led_sequence_checker #(
  parameter int WIDTH      = 8,
  parameter int TIMEOUT    = 24000000,
  parameter int LOCK_STEPS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [WIDTH-1:0] led_in,
  output logic             locked,
  output logic             error,
  output logic [7:0]       err_cnt,
  output logic             stall,
  output logic [CNT_W-1:0] step_cnt
);

  // Idle counter must be able to hold TIMEOUT+1 without wrapping
  localparam int c_TMR_W = $clog2(TIMEOUT + 2);
  localparam int c_RUN_W = $clog2(LOCK_STEPS + 1);
  localparam logic [c_TMR_W-1:0] c_TIMEOUT   = c_TMR_W'(TIMEOUT);
  localparam logic [c_RUN_W-1:0] c_LOCK_LAST = c_RUN_W'(LOCK_STEPS - 1);
  localparam logic [WIDTH-1:0]   c_ONE       = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRACK     = 2'd1,
    LOCKED_ST = 2'd2
  } state_t;

  state_t             r_state,   w_state_nxt;
  logic [c_RUN_W-1:0] r_run,     w_run_nxt;
  logic [c_TMR_W-1:0] r_idle_cnt, w_idle_nxt;
  logic [WIDTH-1:0]   r_prev_led;
  logic               r_mode_q;
  logic               r_locked,  w_locked_nxt;
  logic               r_error,   w_error_nxt;
  logic [7:0]         r_err_cnt, w_err_cnt_nxt;
  logic               r_stall,   w_stall_nxt;
  logic [CNT_W-1:0]   r_step_cnt, w_step_nxt;

  logic               w_change;
  logic               w_onehot;
  logic               w_valid;
  logic               w_over;
  logic [WIDTH-1:0]   w_expected;

  assign locked   = r_locked;
  assign error    = r_error;
  assign err_cnt  = r_err_cnt;
  assign stall    = r_stall;
  assign step_cnt = r_step_cnt;

  // Step classification against the previous sample and the registered direction
  always_comb begin
    w_change   = (led_in != r_prev_led);
    w_expected = r_mode_q ? {r_prev_led[0], r_prev_led[WIDTH-1:1]}
                          : {r_prev_led[WIDTH-2:0], r_prev_led[WIDTH-1]};
    w_onehot   = (led_in != '0) && ((led_in & (led_in - c_ONE)) == '0);
    w_valid    = w_change && (led_in == w_expected) && w_onehot;
    // Counter already at or past TIMEOUT and bus still unchanged: next count exceeds it
    w_over     = !w_change && (r_idle_cnt >= c_TIMEOUT);
  end

  // Next-state and output decisions; priority is mode change, stall, then step
  always_comb begin
    w_state_nxt   = r_state;
    w_run_nxt     = r_run;
    w_locked_nxt  = r_locked;
    w_error_nxt   = 1'b0;
    w_err_cnt_nxt = r_err_cnt;
    w_stall_nxt   = w_change ? 1'b0 : r_stall;
    w_step_nxt    = r_step_cnt;

    if (w_change) begin
      w_idle_nxt = '0;
    end else if (r_idle_cnt <= c_TIMEOUT) begin
      w_idle_nxt = r_idle_cnt + c_TMR_W'(1);
    end else begin
      w_idle_nxt = r_idle_cnt;
    end

    if (mode != r_mode_q) begin
      w_state_nxt  = IDLE;
      w_run_nxt    = '0;
      w_locked_nxt = 1'b0;
      w_step_nxt   = '0;
    end else if (w_over && (r_state != IDLE)) begin
      w_stall_nxt  = 1'b1;
      w_locked_nxt = 1'b0;
      w_state_nxt  = IDLE;
      w_run_nxt    = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_onehot) begin
            w_state_nxt = TRACK;
            w_run_nxt   = '0;
          end
        end
        TRACK: begin
          if (!w_onehot) begin
            w_state_nxt = IDLE;
            w_run_nxt   = '0;
          end else if (w_valid) begin
            w_run_nxt  = r_run + c_RUN_W'(1);
            w_step_nxt = r_step_cnt + CNT_W'(1);
            if (r_run == c_LOCK_LAST) begin
              w_state_nxt  = LOCKED_ST;
              w_locked_nxt = 1'b1;
            end
          end else if (w_change) begin
            // Pre-lock mismatch: silently restart from the new value
            w_run_nxt = '0;
          end
        end
        LOCKED_ST: begin
          if (w_valid) begin
            w_step_nxt = r_step_cnt + CNT_W'(1);
          end else if (w_change) begin
            w_error_nxt   = 1'b1;
            w_err_cnt_nxt = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
            w_locked_nxt  = 1'b0;
            w_step_nxt    = '0;
            w_run_nxt     = '0;
            w_state_nxt   = w_onehot ? TRACK : IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  // State, sample history and output registers
  always_ff @(posedge clk) begin
    r_prev_led <= led_in;
    r_mode_q   <= mode;
    if (reset) begin
      r_state    <= IDLE;
      r_run      <= '0;
      r_idle_cnt <= '0;
      r_locked   <= 1'b0;
      r_error    <= 1'b0;
      r_err_cnt  <= '0;
      r_stall    <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_run      <= w_run_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_locked   <= w_locked_nxt;
      r_error    <= w_error_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      r_stall    <= w_stall_nxt;
      r_step_cnt <= w_step_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_sequence_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_sequence_checker
// Purpose  : Directed self-checking bench for led_sequence_checker
//            (TIMEOUT = 16 build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_sequence_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [7:0]  led_in;
  logic        locked;
  logic        error;
  logic [7:0]  err_cnt;
  logic        stall;
  logic [15:0] step_cnt;

  int checks     = 0;
  int failures   = 0;
  int err_pulses = 0;
  int p0;
  logic [7:0] cur;

  led_sequence_checker #(
    .WIDTH(8), .TIMEOUT(16), .LOCK_STEPS(4), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .led_in(led_in),
    .locked(locked), .error(error), .err_cnt(err_cnt),
    .stall(stall), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // Count every cycle in which error is high
  always @(negedge clk) if (error === 1'b1) err_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] v, input int n);
    led_in = v;
    cur    = v;
    repeat (n) tick();
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic l, input logic e,
                           input logic [7:0] ec, input logic s, input logic [15:0] sc);
    check({tag, ".locked"},   {31'd0, locked}, {31'd0, l});
    check({tag, ".error"},    {31'd0, error},  {31'd0, e});
    check({tag, ".err_cnt"},  {24'd0, err_cnt}, {24'd0, ec});
    check({tag, ".stall"},    {31'd0, stall},  {31'd0, s});
    check({tag, ".step_cnt"}, {16'd0, step_cnt}, {16'd0, sc});
  endtask

  // Mode-0 lock from a start value: start + 4 valid left rotations
  task automatic lock0(input logic [7:0] start, input int hold);
    drive(start, hold);
    for (int k = 0; k < 4; k++) drive(rotl(cur), hold);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    mode   = 1'b0;
    led_in = 8'h00;
    tick();
    reset  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; led_in = 8'h00; cur = 8'h00;
    tick(); tick();
    check_all("reset", 1'b0, 1'b0, 8'd0, 1'b0, 16'd0);
    reset = 1'b0;

    // Lock in mode 0
    drive(8'h01, 3); drive(8'h02, 3); drive(8'h04, 3); drive(8'h08, 3);
    check("prelock.locked", {31'd0, locked}, 32'd0);
    check("prelock.step",   {16'd0, step_cnt}, 32'd3);
    drive(8'h10, 1);
    check_all("lock0", 1'b1, 1'b0, 8'd0, 1'b0, 16'd4);
    drive(8'h10, 2);

    // Wrap through 0x80 -> 0x01
    drive(8'h20, 3); drive(8'h40, 3); drive(8'h80, 3);
    drive(8'h01, 1);
    check_all("wrap", 1'b1, 1'b0, 8'd0, 1'b0, 16'd8);
    drive(8'h01, 1);

    // Direction change drops lock without error
    mode = 1'b1;
    drive(8'h01, 1);
    check_all("modechg", 1'b0, 1'b0, 8'd0, 1'b0, 16'd0);
    drive(8'h01, 2);
    drive(8'h80, 3); drive(8'h40, 3); drive(8'h20, 3);
    check("relock.pre", {31'd0, locked}, 32'd0);
    drive(8'h10, 1);
    check_all("relock", 1'b1, 1'b0, 8'd0, 1'b0, 16'd4);
    drive(8'h10, 2);
    drive(8'h08, 1);
    check("relock.step", {16'd0, step_cnt}, 32'd5);
    check("relock.pulses", err_pulses, 32'd0);

    // Fault while locked
    do_reset();
    check_all("reset2", 1'b0, 1'b0, 8'd0, 1'b0, 16'd0);
    lock0(8'h01, 1);
    check("flt.locked", {31'd0, locked}, 32'd1);
    p0 = err_pulses;
    drive(8'h40, 1);
    check_all("fault", 1'b0, 1'b1, 8'd1, 1'b0, 16'd0);
    drive(8'h40, 1);
    check("fault.pulse_end", {31'd0, error}, 32'd0);
    drive(8'h11, 1);
    check_all("multibit", 1'b0, 1'b0, 8'd1, 1'b0, 16'd0);
    drive(8'h11, 2);
    check("fault.pulses", err_pulses - p0, 32'd1);

    // Stall with TIMEOUT = 16
    do_reset();
    lock0(8'h80, 1);
    check("stall.lock", {31'd0, locked}, 32'd1);
    repeat (16) tick();
    check("stall.c16.stall",  {31'd0, stall},  32'd0);
    check("stall.c16.locked", {31'd0, locked}, 32'd1);
    tick();
    check("stall.c17.stall",  {31'd0, stall},  32'd1);
    check("stall.c17.locked", {31'd0, locked}, 32'd0);
    repeat (3) tick();
    check("stall.hold", {31'd0, stall}, 32'd1);
    drive(8'h10, 1);
    check("stall.clear", {31'd0, stall}, 32'd0);
    drive(8'h20, 1); drive(8'h40, 1); drive(8'h80, 1); drive(8'h01, 1);
    check("stall.retrack", {31'd0, locked}, 32'd1);
    check("stall.nostall", {31'd0, stall}, 32'd0);

    // Saturation: repeated lock / fault cycles
    check("sat.start", {24'd0, err_cnt}, 32'd0);
    for (int i = 0; i < 300; i++) begin
      drive(rotl(rotl(cur)), 1);
      if (i == 0)   check("sat.first", {24'd0, err_cnt}, 32'd1);
      if (i == 254) check("sat.255",   {24'd0, err_cnt}, 32'd255);
      for (int k = 0; k < 4; k++) drive(rotl(cur), 1);
    end
    check("sat.final",  {24'd0, err_cnt}, 32'd255);
    check("sat.locked", {31'd0, locked}, 32'd1);

    // Reset mid-sequence clears every output
    drive(rotl(cur), 1);
    reset = 1'b1;
    tick();
    check_all("midreset", 1'b0, 1'b0, 8'd0, 1'b0, 16'd0);
    reset = 1'b0;

    // Mode toggle coincident with an invalid step while locked
    lock0(8'h01, 1);
    check("sim.locked", {31'd0, locked}, 32'd1);
    p0 = err_pulses;
    mode = 1'b1;
    drive(8'h40, 1);
    check_all("simul", 1'b0, 1'b0, 8'd0, 1'b0, 16'd0);
    drive(8'h40, 2);
    check("simul.pulses", err_pulses - p0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
